// File: rtl/tx_serializer.sv
// tx_serializer: drains a 128-bit AES result block into the byte-wide
// transmit FIFO, MSB byte first.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         synchronous active-high reset
//   data_done     one-cycle pulse, aes_data_out valid this cycle
//   aes_data_out  128-bit block, bits 127:120 go out first
//   fullTx        transmit FIFO full, no enqueue while high
//   abort         cancel the block in progress
//   trans_enq     FIFO write strobe, one byte per high cycle
//   tx_byte       byte presented to the FIFO (top byte of the shift register)
//   ser_ready     a data_done this cycle will be accepted
//   block_sent    one-cycle pulse after the 16th byte is enqueued
//   overflow      sticky: data_done arrived while busy
//   byte_count    bytes of the current block already enqueued (0..16)
module tx_serializer (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_done,
    input  logic [127:0] aes_data_out,
    input  logic         fullTx,
    input  logic         abort,
    output logic         trans_enq,
    output logic [7:0]   tx_byte,
    output logic         ser_ready,
    output logic         block_sent,
    output logic         overflow,
    output logic [4:0]   byte_count
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] shift_q, shift_d;
    logic [4:0]   count_q, count_d;
    logic         overflow_q, overflow_d;

    // Outputs depend only on state and the live inputs.
    always_comb begin
        trans_enq  = 1'b0;
        ser_ready  = 1'b1;
        block_sent = 1'b0;
        unique case (state_q)
            StIdle: ;
            StSend: begin
                ser_ready = 1'b0;
                // An abort or reset cycle must never write a byte.
                trans_enq = !fullTx && !abort && !reset;
            end
            StDone: block_sent = 1'b1;
            default: ;
        endcase
    end

    assign tx_byte    = shift_q[127:120];
    assign overflow   = overflow_q;
    assign byte_count = count_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (abort) begin
            // Abort wins over data_done: block dropped, overflow untouched.
            state_d = StIdle;
            count_d = 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (data_done) begin
                        shift_d = aes_data_out;
                        count_d = 5'd0;
                        state_d = StSend;
                    end
                end
                StSend: begin
                    if (data_done) begin
                        overflow_d = 1'b1;
                    end
                    if (trans_enq) begin
                        shift_d = {shift_q[119:0], 8'h00};
                        count_d = count_q + 5'd1;
                        if (count_q == 5'd15) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    count_d = 5'd0;
                    if (data_done) begin
                        shift_d = aes_data_out;
                        state_d = StSend;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: nominal block, backpressure, overflow,
// back-to-back blocks, reset and abort behaviour.
module tb_tx_serializer;

    logic         tb_clk = 1'b0;
    logic         reset;
    logic         data_done;
    logic [127:0] aes_data_out;
    logic         fullTx;
    logic         abort;
    logic         trans_enq;
    logic [7:0]   tx_byte;
    logic         ser_ready;
    logic         block_sent;
    logic         overflow;
    logic [4:0]   byte_count;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] BlkLo = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BlkHi = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    localparam logic [127:0] BlkFf = 128'hffeeddccbbaa99887766554433221100;

    tx_serializer dut (
        .clk          (tb_clk),
        .reset        (reset),
        .data_done    (data_done),
        .aes_data_out (aes_data_out),
        .fullTx       (fullTx),
        .abort        (abort),
        .trans_enq    (trans_enq),
        .tx_byte      (tx_byte),
        .ser_ready    (ser_ready),
        .block_sent   (block_sent),
        .overflow     (overflow),
        .byte_count   (byte_count)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge tb_clk);
        #2;
    endtask

    // Expect bytes base+from .. base+to to be enqueued on consecutive cycles.
    task automatic send_bytes(input logic [7:0] base, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            #1;
            chk($sformatf("enq[%0d]", i), 128'(trans_enq), 128'(1'b1));
            chk($sformatf("byte[%0d]", i), 128'(tx_byte), 128'(base + 8'(i)));
            chk($sformatf("count[%0d]", i), 128'(byte_count), 128'(i));
            chk($sformatf("nosent[%0d]", i), 128'(block_sent), 128'(1'b0));
            tick();
        end
    endtask

    task automatic load(input logic [127:0] blk);
        data_done    = 1'b1;
        aes_data_out = blk;
        tick();
        data_done    = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        #1;
        chk({tag, "_sent"}, 128'(block_sent), 128'(1'b1));
        chk({tag, "_cnt16"}, 128'(byte_count), 128'(5'd16));
        chk({tag, "_noenq"}, 128'(trans_enq), 128'(1'b0));
    endtask

    initial begin
        reset        = 1'b1;
        data_done    = 1'b0;
        aes_data_out = '0;
        fullTx       = 1'b0;
        abort        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_enq", 128'(trans_enq), 128'(1'b0));
        chk("rst_byte", 128'(tx_byte), 128'(8'h00));
        chk("rst_ready", 128'(ser_ready), 128'(1'b1));
        chk("rst_sent", 128'(block_sent), 128'(1'b0));
        chk("rst_ovf", 128'(overflow), 128'(1'b0));
        chk("rst_cnt", 128'(byte_count), 128'(5'd0));

        // Nominal block
        tick();
        load(BlkLo);
        send_bytes(8'h00, 0, 15);
        expect_done("nom");
        tick();
        #1;
        chk("nom_idle_ready", 128'(ser_ready), 128'(1'b1));
        chk("nom_idle_sent", 128'(block_sent), 128'(1'b0));
        chk("nom_idle_cnt", 128'(byte_count), 128'(5'd0));
        chk("nom_idle_enq", 128'(trans_enq), 128'(1'b0));

        // Backpressure after byte 5
        tick();
        load(BlkHi);
        send_bytes(8'ha0, 0, 4);
        fullTx = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_noenq", 128'(trans_enq), 128'(1'b0));
            chk("bp_cnt", 128'(byte_count), 128'(5'd5));
            chk("bp_byte", 128'(tx_byte), 128'(8'ha5));
            tick();
        end
        fullTx = 1'b0;
        send_bytes(8'ha0, 5, 15);
        expect_done("bp");
        tick();

        // Overflow: second data_done at byte 8
        load(BlkLo);
        send_bytes(8'h00, 0, 7);
        data_done    = 1'b1;
        aes_data_out = BlkFf;
        #1;
        chk("ovf_enq8", 128'(trans_enq), 128'(1'b1));
        chk("ovf_byte8", 128'(tx_byte), 128'(8'h08));
        tick();
        data_done = 1'b0;
        #1;
        chk("ovf_set", 128'(overflow), 128'(1'b1));
        send_bytes(8'h00, 9, 15);
        expect_done("ovf");
        tick();
        #1;
        chk("ovf_idle_enq", 128'(trans_enq), 128'(1'b0));
        chk("ovf_idle_ready", 128'(ser_ready), 128'(1'b1));
        chk("ovf_sticky", 128'(overflow), 128'(1'b1));

        // Back-to-back: next block accepted in DONE cycle
        tick();
        load(BlkLo);
        send_bytes(8'h00, 0, 15);
        expect_done("b2b1");
        data_done    = 1'b1;
        aes_data_out = BlkHi;
        tick();
        data_done = 1'b0;
        send_bytes(8'ha0, 0, 15);
        expect_done("b2b2");
        tick();
        #1;
        chk("b2b_idle_sent", 128'(block_sent), 128'(1'b0));

        // Reset at byte 7 with overflow set (data_done held too)
        tick();
        load(BlkHi);
        send_bytes(8'ha0, 0, 6);
        #1;
        chk("prerst_ovf", 128'(overflow), 128'(1'b1));
        reset     = 1'b1;
        data_done = 1'b1;
        tick();
        reset     = 1'b0;
        data_done = 1'b0;
        #1;
        chk("mrst_enq", 128'(trans_enq), 128'(1'b0));
        chk("mrst_cnt", 128'(byte_count), 128'(5'd0));
        chk("mrst_ovf", 128'(overflow), 128'(1'b0));
        chk("mrst_ready", 128'(ser_ready), 128'(1'b1));
        chk("mrst_byte", 128'(tx_byte), 128'(8'h00));
        tick();
        #1;
        chk("mrst_enq2", 128'(trans_enq), 128'(1'b0));

        // Abort at byte 10, then a clean block
        tick();
        load(BlkLo);
        send_bytes(8'h00, 0, 9);
        abort = 1'b1;
        #1;
        chk("abt_noenq", 128'(trans_enq), 128'(1'b0));
        tick();
        abort = 1'b0;
        #1;
        chk("abt_cnt", 128'(byte_count), 128'(5'd0));
        chk("abt_ready", 128'(ser_ready), 128'(1'b1));
        chk("abt_sent", 128'(block_sent), 128'(1'b0));
        chk("abt_enq", 128'(trans_enq), 128'(1'b0));
        tick();
        #1;
        chk("abt_sent2", 128'(block_sent), 128'(1'b0));
        load(BlkHi);
        send_bytes(8'ha0, 0, 15);
        expect_done("abt_after");
        tick();

        // Abort beats data_done mid-block: no overflow, back to idle
        load(BlkLo);
        send_bytes(8'h00, 0, 1);
        abort        = 1'b1;
        data_done    = 1'b1;
        aes_data_out = BlkFf;
        tick();
        abort     = 1'b0;
        data_done = 1'b0;
        #1;
        chk("pri_ovf", 128'(overflow), 128'(1'b0));
        chk("pri_ready", 128'(ser_ready), 128'(1'b1));
        chk("pri_cnt", 128'(byte_count), 128'(5'd0));
        chk("pri_enq", 128'(trans_enq), 128'(1'b0));

        // fullTx high at load, falls on the first SEND cycle
        tick();
        fullTx = 1'b1;
        load(BlkHi);
        fullTx = 1'b0;
        send_bytes(8'ha0, 0, 15);
        expect_done("fall");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_serializer.md
TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 The block SHALL have a single clock domain, with one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 data_done  input  1  single-cycle pulse from AES core: aes_data_out holds a valid 128-bit result this cycle.
REQ-005 aes_data_out  input  128  AES result block; bits 127:120 are the first byte on the wire.
REQ-006 fullTx  input  1  transmit FIFO full flag; no enqueue when high.
REQ-007 abort  input  1  MCU-driven cancel of the block in progress.
REQ-008 trans_enq  output  1  transmit FIFO write strobe; one byte written per high cycle.
REQ-009 tx_byte  output  8  byte presented to transmit FIFO, valid whenever trans_enq is high.
REQ-010 ser_ready  output  1  high when a new data_done will be accepted this cycle.
REQ-011 block_sent  output  1  single-cycle pulse after the 16th byte of a block is enqueued.
REQ-012 overflow  output  1  sticky error: a data_done arrived while not ready; cleared only by reset.
REQ-013 byte_count  output  5  bytes of current block already enqueued, 0..16.

Function
REQ-014 The block SHALL be an FSM with states IDLE, SEND and DONE.
REQ-015 The block SHALL keep a 128-bit shift register; tx_byte SHALL always equal its bits 127:120.
REQ-016 ser_ready SHALL be 1 in IDLE and DONE and 0 in SEND.
REQ-017 IDLE: data_done=1 SHALL load aes_data_out into the shift register, clear byte_count, and go to SEND on the next edge.
REQ-018 SEND: trans_enq SHALL equal NOT fullTx, combinationally from state and fullTx; no other cycle SHALL assert trans_enq.
REQ-019 SEND: each edge with trans_enq=1 SHALL shift the register left by 8 (zero fill) and increment byte_count.
REQ-020 SEND: edges with fullTx=1 SHALL leave the shift register and byte_count unchanged, with no loss or duplication of bytes.
REQ-021 SEND: the edge that performs the 16th enqueue SHALL move the FSM to DONE with byte_count=16.
REQ-022 DONE SHALL last exactly one cycle and assert block_sent=1 for that cycle.
REQ-023 DONE: data_done=1 SHALL load the new block and go to SEND; otherwise the FSM SHALL go to IDLE with byte_count cleared to 0.
REQ-024 Minimum latency SHALL be: first trans_enq in the cycle after the data_done edge; 16 consecutive enqueue cycles when fullTx=0; block_sent in the 17th cycle after that edge.
REQ-025 data_done=1 while in SEND SHALL set overflow=1, drop the new block, and leave the current transfer unaffected.
REQ-026 abort=1 in any state SHALL force IDLE and byte_count=0 on the next edge, with trans_enq=0 in the abort cycle.
REQ-027 abort SHALL take priority over data_done in the same cycle; the block SHALL be dropped and overflow SHALL not be set.
REQ-028 block_sent SHALL not pulse for an aborted block.
REQ-029 If fullTx falls in the same cycle the FSM enters SEND, the enqueue SHALL occur that cycle.

Reset
REQ-030 While reset=1 at an edge, the FSM SHALL go to IDLE, the shift register SHALL be cleared to 0, byte_count=0 and overflow=0.
REQ-031 After reset, outputs SHALL be trans_enq=0, tx_byte=8'h00, ser_ready=1 and block_sent=0.
REQ-032 Reset SHALL override data_done and abort.
REQ-033 Reset mid-SEND SHALL discard remaining bytes, with no further trans_enq.

Verification
REQ-034 Nominal block: data_done with aes_data_out=128'h000102...0F, fullTx=0 -> trans_enq high 16 consecutive cycles, tx_byte 00,01,...,0F in order, block_sent one cycle later, then IDLE.
REQ-035 Backpressure: fullTx=1 for 3 cycles after byte 5 -> trans_enq=0 for those cycles, byte_count holds at 5, next byte is 05, 16 bytes total with no duplicates.
REQ-036 Overflow: second data_done at byte 8 -> overflow=1 and stays 1, first block completes intact, second block never emitted.
REQ-037 Back-to-back blocks: data_done in the DONE cycle -> new block's first byte enqueued the next cycle, block_sent pulses once per block.
REQ-038 Abort at byte_count=10 -> IDLE next edge, byte_count=0, no block_sent, and a later block is serialized correctly from byte 0.
REQ-039 Reset at byte_count=7 with overflow=1 -> trans_enq=0, byte_count=0, overflow=0, ser_ready=1 after the edge.
